// File: rtl/rowwise_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier among NumReq requesters.
// The datapath is two registered stages (operands, result) with valid/ready backpressure.

package config_pkg;
  localparam int FixedPointPrecision = 16;
  localparam int FixedPointExponent  = -8;
  localparam int FixedPointMax       = 2 ** (FixedPointPrecision - 1) - 1;
  localparam int FixedPointMin       = -(2 ** (FixedPointPrecision - 1));
  localparam int unsigned FixedShift = (FixedPointExponent < 0) ? -FixedPointExponent
                                                                 : FixedPointExponent;

  typedef logic signed [FixedPointPrecision-1:0]   fixed_point_t;
  typedef logic signed [2*FixedPointPrecision-1:0] fixed_wide_t;

  // Full-width product rescaled by the exponent, before clamping.
  function automatic fixed_wide_t fixed_mul_scaled(input fixed_point_t a, input fixed_point_t b);
    fixed_wide_t p;
    p = fixed_wide_t'(a) * fixed_wide_t'(b);
    if (FixedPointExponent < 0) return p >>> FixedShift;
    else                        return p <<< FixedShift;
  endfunction

  function automatic logic fixed_is_sat(input fixed_wide_t v);
    return (v > fixed_wide_t'(FixedPointMax)) || (v < fixed_wide_t'(FixedPointMin));
  endfunction
endpackage

module rowwise_mul
  import config_pkg::*;
(
  input  fixed_point_t a_i,
  input  fixed_point_t b_i,
  output fixed_point_t y_o
);
  fixed_wide_t scaled;

  always_comb begin
    scaled = fixed_mul_scaled(a_i, b_i);
    if (scaled > fixed_wide_t'(FixedPointMax))      y_o = fixed_point_t'(FixedPointMax);
    else if (scaled < fixed_wide_t'(FixedPointMin)) y_o = fixed_point_t'(FixedPointMin);
    else                                            y_o = scaled[FixedPointPrecision-1:0];
  end
endmodule

module rowwise_mul_arbiter
  import config_pkg::*;
#(
  parameter int NumReq  = 4,
  parameter int IdW     = $clog2(NumReq),
  parameter int SatCntW = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumReq-1:0]  req_valid_i,
  output logic [NumReq-1:0]  req_ready_o,
  input  fixed_point_t       req_a_i [NumReq],
  input  fixed_point_t       req_b_i [NumReq],
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output fixed_point_t       rsp_y_o,
  output logic [IdW-1:0]     rsp_id_o,
  output logic               rsp_sat_o,
  input  logic               sat_clear_i,
  output logic [SatCntW-1:0] sat_count_o,
  output logic               busy_o
);
  logic [IdW-1:0] ptr;
  logic [IdW-1:0] grant_idx;
  logic           grant_found;
  int             cand;

  logic           s1_valid, s2_valid;
  logic           s1_accept, s1_advance, s2_accept;
  logic           req_fire, rsp_fire;
  fixed_point_t   s1_a, s1_b, mul_y;
  logic [IdW-1:0] s1_id;
  logic           s1_sat;

  assign s2_accept  = !s2_valid || rsp_ready_i;
  assign s1_advance = s1_valid && s2_accept;
  assign s1_accept  = !s1_valid || s1_advance;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NumReq; i++) begin
      cand = (int'(ptr) + i) % NumReq;
      if (!grant_found && req_valid_i[cand[IdW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IdW-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_found && s1_accept && !rst_i) req_ready_o[grant_idx] = 1'b1;
  end

  assign req_fire = grant_found && s1_accept && !rst_i;
  assign rsp_fire = s2_valid && rsp_ready_i;

  rowwise_mul u_mul (
    .a_i (s1_a),
    .b_i (s1_b),
    .y_o (mul_y)
  );

  assign s1_sat = fixed_is_sat(fixed_mul_scaled(s1_a, s1_b));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      rsp_y_o  <= '0;
      rsp_id_o <= '0;
      rsp_sat_o <= 1'b0;
    end else begin
      if (req_fire) ptr <= IdW'((int'(grant_idx) + 1) % NumReq);

      if (s1_accept) begin
        s1_valid <= req_fire;
        if (req_fire) begin
          s1_a  <= req_a_i[grant_idx];
          s1_b  <= req_b_i[grant_idx];
          s1_id <= grant_idx;
        end
      end

      // Result registers only load on real data, so they hold while stalled.
      if (s2_accept) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          rsp_y_o   <= mul_y;
          rsp_id_o  <= s1_id;
          rsp_sat_o <= s1_sat;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                           sat_count_o <= '0;
    else if (sat_clear_i)                                sat_count_o <= '0;
    else if (rsp_fire && rsp_sat_o && (sat_count_o != '1)) sat_count_o <= sat_count_o + 1'b1;
  end

  assign rsp_valid_o = s2_valid;
  assign busy_o      = s1_valid || s2_valid;
endmodule
